// File: rtl/cvxif_mac_issue_if.sv
// Issue and result channels between the core's CV-X-IF port and the
// byte-dot-product issue controller.
interface cvxif_mac_issue_if #(
  parameter int unsigned ID_W = 3,
  parameter int unsigned RD_W = 5
);
  logic            issue_valid;
  logic            issue_ready;
  logic [ID_W-1:0] issue_id;
  logic [RD_W-1:0] issue_rd;
  logic [31:0]     issue_rs1;
  logic [31:0]     issue_rs2;

  logic            result_valid;
  logic            result_ready;
  logic [ID_W-1:0] result_id;
  logic [RD_W-1:0] result_rd;
  logic [31:0]     result_data;
  logic            result_we;

  modport master (
    output issue_valid, issue_id, issue_rd,
    output issue_rs1, issue_rs2, result_ready,
    input  issue_ready, result_valid, result_id,
    input  result_rd, result_data, result_we
  );

  modport slave (
    input  issue_valid, issue_id, issue_rd,
    input  issue_rs1, issue_rs2, result_ready,
    output issue_ready, result_valid, result_id,
    output result_rd, result_data, result_we
  );
endinterface

// File: rtl/cvxif_mac_issue.sv
// CV-X-IF issue controller for the byte dot-product MAC.
// Credits bound in-flight work so the non-stallable MAC always finds a slot.
module cvxif_mac_issue #(
  parameter int unsigned ID_W     = 3,
  parameter int unsigned RD_W     = 5,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cvxif_mac_issue_if.slave bus,
  output logic             mac_valid_o,
  output logic [31:0]      mac_operand_a_o,
  output logic [31:0]      mac_operand_b_o,
  input  logic             mac_result_valid_i,
  input  logic [31:0]      mac_result_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = ID_W + RD_W;
  localparam int unsigned RW = TW + 32;

  if (PIPE_LAT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("cvxif_mac_issue: DEPTH must be a power of two >= 2, PIPE_LAT >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          issue_fire;
  logic          res_fire;

  logic          mac_valid_q;
  logic [31:0]   op_a_q;
  logic [31:0]   op_b_q;
  logic          err_q, err_d;

  logic [TW-1:0] tag_mem_q [DEPTH];
  logic [PW-1:0] tag_wp_q, tag_rp_q;
  logic [TW-1:0] tag_head;
  logic          tag_empty;
  logic          tag_pop;

  logic [RW-1:0] res_mem_q [DEPTH];
  logic [PW-1:0] res_wp_q, res_rp_q;
  logic [RW-1:0] res_head;
  logic          res_empty;

  // Ready comes from the credit register alone, never from inputs.
  assign bus.issue_ready = (cnt_q < CW'(DEPTH));
  assign issue_fire      = bus.issue_valid & bus.issue_ready;
  assign res_fire        = bus.result_valid & bus.result_ready;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue_fire, res_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign tag_empty = (tag_wp_q == tag_rp_q);
  assign tag_head  = tag_mem_q[tag_rp_q[AW-1:0]];
  assign tag_pop   = mac_result_valid_i & ~tag_empty;

  // A result with no tag to pair with is dropped and flagged for good.
  assign err_d = err_q | (mac_result_valid_i & tag_empty);

  assign res_empty = (res_wp_q == res_rp_q);
  assign res_head  = res_mem_q[res_rp_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      mac_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mac_valid_q <= issue_fire;
      err_q       <= err_d;
      if (issue_fire) begin
        op_a_q <= bus.issue_rs1;
        op_b_q <= bus.issue_rs2;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_wp_q <= '0;
      tag_rp_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      if (issue_fire) begin
        tag_mem_q[tag_wp_q[AW-1:0]] <= {bus.issue_id, bus.issue_rd};
        tag_wp_q <= tag_wp_q + 1'b1;
      end
      if (tag_pop) begin
        tag_rp_q <= tag_rp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_wp_q <= '0;
      res_rp_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        res_mem_q[i] <= '0;
      end
    end else begin
      if (tag_pop) begin
        res_mem_q[res_wp_q[AW-1:0]] <= {tag_head, mac_result_i};
        res_wp_q <= res_wp_q + 1'b1;
      end
      if (res_fire) begin
        res_rp_q <= res_rp_q + 1'b1;
      end
    end
  end

  assign mac_valid_o     = mac_valid_q;
  assign mac_operand_a_o = op_a_q;
  assign mac_operand_b_o = op_b_q;

  assign bus.result_valid = ~res_empty;
  assign bus.result_we    = ~res_empty;
  assign bus.result_id    = res_head[RW-1 -: ID_W];
  assign bus.result_rd    = res_head[32 +: RD_W];
  assign bus.result_data  = res_head[31:0];

  assign busy_o = (cnt_q != '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_cvxif_mac_issue.sv
// Bench for cvxif_mac_issue: vector table, scoreboard and corner sequences
// around a behavioural byte dot-product MAC.
module tb_cvxif_mac_issue;
  localparam int ID_W     = 3;
  localparam int RD_W     = 5;
  localparam int DEPTH    = 4;
  localparam int PIPE_LAT = 2;
  localparam int EW       = ID_W + RD_W + 32;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [RD_W-1:0] rd;
    logic [31:0]     rs1;
    logic [31:0]     rs2;
    logic [31:0]     data;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        spur  = 1'b0;
  logic        mac_valid;
  logic [31:0] mac_a, mac_b;
  logic        mac_rv;
  logic [31:0] mac_r;
  logic        busy, err;

  int n_chk   = 0;
  int n_pass  = 0;
  int n_pop   = 0;
  int max_out = 0;

  logic [EW-1:0] exp_q [$];
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_head;
  logic [EW-1:0] head;

  always #5 clk = ~clk;

  cvxif_mac_issue_if #(.ID_W(ID_W), .RD_W(RD_W)) bus ();

  cvxif_mac_issue #(
    .ID_W(ID_W), .RD_W(RD_W), .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .bus                (bus),
    .mac_valid_o        (mac_valid),
    .mac_operand_a_o    (mac_a),
    .mac_operand_b_o    (mac_b),
    .mac_result_valid_i (mac_rv),
    .mac_result_i       (mac_r),
    .busy_o             (busy),
    .err_o              (err)
  );

  function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++)
      s += int'(a[8*i +: 8]) * int'($signed(b[8*i +: 8]));
    return s;
  endfunction

  // MAC model: the operand register inside the DUT is the first of the
  // PIPE_LAT stages, so the model adds PIPE_LAT-1 more.
  logic        mv_q [PIPE_LAT-1];
  logic [31:0] md_q [PIPE_LAT-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT - 1; i++) begin
        mv_q[i] <= 1'b0;
        md_q[i] <= '0;
      end
    end else begin
      mv_q[0] <= mac_valid;
      md_q[0] <= dot(mac_a, mac_b);
      for (int i = 1; i < PIPE_LAT - 1; i++) begin
        mv_q[i] <= mv_q[i-1];
        md_q[i] <= md_q[i-1];
      end
    end
  end

  assign mac_rv = mv_q[PIPE_LAT-2] | spur;
  assign mac_r  = md_q[PIPE_LAT-2];
  assign head   = {bus.result_id, bus.result_rd, bus.result_data};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Scoreboard and stall-stability monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {23'd0, bus.result_valid, head}, {23'd0, 1'b1, prev_head});
      if (bus.issue_valid && bus.issue_ready)
        exp_q.push_back({bus.issue_id, bus.issue_rd, dot(bus.issue_rs1, bus.issue_rs2)});
      if (bus.result_valid && bus.result_ready) begin
        n_pop++;
        chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("sb_result", 64'(head), 64'(exp_q.pop_front()));
          chk("sb_we", 64'(bus.result_we), 64'd1);
        end
      end
      if (exp_q.size() > max_out) max_out = exp_q.size();
      prev_stall = bus.result_valid && !bus.result_ready;
      prev_head  = head;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic rr, input logic [ID_W-1:0] id);
    bus.issue_valid  = v;
    bus.result_ready = rr;
    bus.issue_id     = id;
    bus.issue_rd     = RD_W'($urandom);
    bus.issue_rs1    = $urandom;
    bus.issue_rs2    = $urandom;
  endtask

  task automatic drain(input string nm);
    int k = 0;
    bus.issue_valid  = 1'b0;
    bus.result_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.result_valid) && k < 40) begin
      step();
      k++;
    end
    chk(nm, 64'(exp_q.size() != 0 || bus.result_valid), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [4];
    int   acc;
    int   n0;
    logic stale;

    vecs[0] = '{id: 3'd2, rd: 5'd7,  rs1: 32'h01020304, rs2: 32'h01010101, data: 32'd10};
    vecs[1] = '{id: 3'd3, rd: 5'd1,  rs1: 32'h01020304, rs2: 32'hFFFFFFFF, data: 32'hFFFFFFF6};
    vecs[2] = '{id: 3'd5, rd: 5'd31, rs1: 32'hFF000000, rs2: 32'h80000000, data: 32'hFFFF8080};
    vecs[3] = '{id: 3'd0, rd: 5'd0,  rs1: 32'hFFFFFFFF, rs2: 32'h7F7F7F7F, data: 32'h0001FA04};

    drv(1'b0, 1'b0, '0);
    bus.issue_rd  = '0;
    bus.issue_rs1 = '0;
    bus.issue_rs2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_flags", 64'({mac_valid, bus.result_valid, bus.result_we, busy, err}), 64'd0);
    chk("rst_operands", {mac_a, mac_b}, 64'd0);
    chk("rst_result", 64'(head), 64'd0);
    rst_n = 1'b1;
    step();

    // Single issues from the vector table, checked cycle by cycle.
    for (int v = 0; v < 4; v++) begin
      bus.issue_valid  = 1'b1;
      bus.result_ready = 1'b1;
      bus.issue_id     = vecs[v].id;
      bus.issue_rd     = vecs[v].rd;
      bus.issue_rs1    = vecs[v].rs1;
      bus.issue_rs2    = vecs[v].rs2;
      @(negedge clk);
      chk("vec_accept", 64'(bus.issue_ready), 64'd1);
      step();
      bus.issue_valid = 1'b0;
      @(negedge clk);
      chk("vec_mac_valid", 64'(mac_valid), 64'd1);
      chk("vec_operands", {mac_a, mac_b}, {vecs[v].rs1, vecs[v].rs2});
      step();
      @(negedge clk);
      chk("vec_mac_once", 64'({mac_valid, bus.result_valid}), 64'd0);
      step();
      @(negedge clk);
      chk("vec_res_valid", 64'({bus.result_valid, bus.result_we}), 64'd3);
      chk("vec_res_data", 64'(bus.result_data), 64'(vecs[v].data));
      chk("vec_res_tag", 64'({bus.result_id, bus.result_rd}), 64'({vecs[v].id, vecs[v].rd}));
      step();
      @(negedge clk);
      chk("vec_idle", 64'({bus.result_valid, busy}), 64'd0);
      step();
    end

    // Backpressure: six back-to-back requests with the result port stalled.
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, 1'b0, ID_W'(i));
      @(negedge clk);
      chk("bp_ready", 64'(bus.issue_ready), 64'(i < DEPTH));
      if (bus.issue_ready) acc++;
      step();
    end
    drv(1'b0, 1'b0, '0);
    repeat (4) step();
    chk("bp_accepted", 64'(acc), 64'(DEPTH));
    chk("bp_ready_low", 64'(bus.issue_ready), 64'd0);
    chk("bp_head_id", 64'(bus.result_id), 64'd0);
    drv(1'b0, 1'b1, '0);
    @(negedge clk);
    chk("bp_first_pop_ready", 64'({bus.issue_ready, bus.result_id}), 64'({1'b0, 3'd0}));
    step();
    @(negedge clk);
    chk("bp_ready_back", 64'({bus.issue_ready, bus.result_id}), 64'({1'b1, 3'd1}));
    step();
    drain("bp_drain");

    // Streaming: 16 issues, ids wrapping, one accept per cycle.
    n0 = n_pop;
    max_out = 0;
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 1'b1, ID_W'(i % 8));
      @(negedge clk);
      chk("stream_ready", 64'(bus.issue_ready), 64'd1);
      step();
    end
    drain("stream_drain");
    chk("stream_count", 64'(n_pop - n0), 64'd16);
    chk("stream_max_inflight", 64'(max_out <= DEPTH), 64'd1);

    // Simultaneous issue and result handshakes at full and at half credit.
    for (int i = 0; i < DEPTH; i++) begin
      drv(1'b1, 1'b0, ID_W'(i));
      step();
    end
    drv(1'b0, 1'b0, '0);
    repeat (4) step();
    drv(1'b1, 1'b1, 3'd4);
    @(negedge clk);
    chk("sim_full", 64'({bus.issue_ready, bus.result_valid}), 64'b01);
    step();
    drv(1'b0, 1'b1, '0);
    @(negedge clk);
    chk("sim_pop_ready", 64'(bus.issue_ready), 64'd1);
    step();
    drv(1'b1, 1'b1, 3'd5);
    @(negedge clk);
    chk("sim_half", 64'({bus.issue_ready, bus.result_valid}), 64'b11);
    step();
    for (int j = 0; j < 3; j++) begin
      drv(1'b1, 1'b0, ID_W'(6 + j));
      @(negedge clk);
      chk("sim_refill", 64'(bus.issue_ready), 64'(j < 2));
      step();
    end
    drain("sim_drain");

    // Reset with three instructions outstanding.
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, ID_W'(i));
      step();
    end
    drv(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_ready", 64'(bus.issue_ready), 64'd1);
    chk("mid_rst_flags", 64'({mac_valid, bus.result_valid, bus.result_we, busy, err}), 64'd0);
    chk("mid_rst_operands", {mac_a, mac_b}, 64'd0);
    chk("mid_rst_result", 64'(head), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.result_ready = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      stale = stale | bus.result_valid;
      step();
    end
    chk("mid_rst_no_stale", 64'(stale), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);

    // Spurious MAC result with nothing in flight.
    spur = 1'b1;
    step();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_err", 64'({err, bus.result_valid}), 64'b10);
    step();
    repeat (3) step();
    @(negedge clk);
    chk("spur_sticky", 64'({err, bus.result_valid, busy}), 64'b100);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
